// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size codes, pipeline stage record and alignment helper for dmem_pipelined
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;
  typedef struct packed {
    logic        valid;
    logic        fault;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] data;
  } dmem_stage_t;
  function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00);
  endfunction
endpackage

// File: rtl/dmem_pipelined_if.sv
// dmem_pipelined_if: valid/ready request and response bus between the load/store unit and dmem_pipelined
interface dmem_pipelined_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_fault;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/dmem_extend.sv
// dmem_extend: rotates the access's first byte into the top lane, then sign/zero extends bytes and halfwords
module dmem_extend import dmem_pkg::*; (
  input  logic [31:0] raw_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);
  logic [4:0]  sh;
  logic [31:0] w;
  always_comb begin
    sh = {off_i, 3'b000};
    w = (raw_i << sh) | (raw_i >> (6'd32 - {1'b0, sh}));
    data_o = size_i == SZ_BYTE ? {{24{!uns_i && w[31]}}, w[31:24]} :
             size_i == SZ_HALF ? {{16{!uns_i && w[31]}}, w[31:16]} : w;
  end
endmodule

// File: rtl/dmem_pipelined.sv
// dmem_pipelined: big-endian byte-addressed data memory with READ_LAT-stage response pipeline and backpressure
// Define DMEM_ALIGN_CHECK_EN to fault misaligned halfword/word accesses; otherwise they wrap byte by byte.
module dmem_pipelined import dmem_pkg::*; #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 256,
  parameter int READ_LAT    = 1
) (
  input logic clk,
  input logic rst,
  dmem_pipelined_if.slave bus
);
  localparam int IW = $clog2(DEPTH_BYTES);
  logic [7:0]    mem_q [DEPTH_BYTES];
  dmem_stage_t   st_q [READ_LAT];
  dmem_stage_t   st_d;
  dmem_stage_t   o;
  logic          adv, acc, bad, unused_addr;
  logic [IW-1:0] a;
  logic [2:0]    nb;
  logic [31:0]   wl, ext;
  assign unused_addr = ^bus.req_addr;
  assign adv = !st_q[READ_LAT-1].valid || bus.rsp_ready;
  assign bus.req_ready = adv && !rst;
  assign acc = bus.req_valid && bus.req_ready;
  assign a = bus.req_addr[IW-1:0];
`ifdef DMEM_ALIGN_CHECK_EN
  assign bad = bus.req_size == SZ_RSVD || dmem_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign bad = bus.req_size == SZ_RSVD;
`endif
  assign nb = bus.req_size == SZ_BYTE ? 3'd1 : bus.req_size == SZ_HALF ? 3'd2 : 3'd4;
  assign wl = bus.req_size == SZ_BYTE ? {bus.req_wdata[7:0], 24'b0} :
              bus.req_size == SZ_HALF ? {bus.req_wdata[15:0], 16'b0} : bus.req_wdata;
  // Byte addr+i lands in lane (off+i)&3, so aligned words appear in natural lane order
  always_comb begin
    st_d = '0;
    st_d.valid = acc;
    st_d.fault = bad;
    st_d.we = bus.req_we;
    st_d.size = bus.req_size;
    st_d.uns = bus.req_unsigned;
    st_d.off = a[1:0];
    for (int j = 0; j < 4; j++)
      st_d.data[31-8*j -: 8] = mem_q[a + IW'((j - int'(a[1:0])) & 3)];
  end
  always_ff @(posedge clk)
    if (acc && bus.req_we && !bad)
      for (int i = 0; i < 4; i++)
        if (i < int'(nb)) mem_q[a + IW'(i)] <= wl[31-8*i -: 8];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < READ_LAT; k++) st_q[k] <= '0;
    end else if (adv) begin
      st_q[0] <= st_d;
      for (int k = 1; k < READ_LAT; k++) st_q[k] <= st_q[k-1];
    end
  assign o = st_q[READ_LAT-1];
  dmem_extend u_ext (.raw_i(o.data), .off_i(o.off), .size_i(o.size), .uns_i(o.uns), .data_o(ext));
  assign bus.rsp_valid = o.valid;
  assign bus.rsp_fault = o.valid && o.fault;
  assign bus.rsp_rdata = o.valid && !o.we && !o.fault ? ext : '0;
endmodule

// File: doc/dmem_pipelined.md
# dmem_pipelined

Parametrised, byte-addressed, big-endian data memory for the single-cycle/pipelined CPU datapath. It replaces the unclocked-read word memory with:
- a valid/ready request port;
- byte, halfword and word accesses with sign or zero extension;
- a configurable read-latency pipeline with response backpressure.

It sits between the CPU load/store unit and on-chip RAM, and it returns one in-order response per accepted request.

## Interface
Parameters:
- `ADDR_W`, default 32: request address width.
- `DEPTH_BYTES`, default 256: memory size in bytes. Must be a power of two and at least 4.
- `READ_LAT`, default 1: number of pipeline stages from acceptance to response. Legal range 1..4.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: request accepted on an edge where `req_valid && req_ready`.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: access size. 0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- `req_unsigned`  in  1: load zero-extends when 1 and sign-extends when 0.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  32: store data, taken from the low-order bytes.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer accepts the response.
- `rsp_rdata`  out  32: extended load data; 0 for stores and faults.
- `rsp_fault`  out  1: the access was rejected.

## Operation
- **Byte order:** the byte at address A maps to bits 31:24 of a word access. A halfword at A occupies bits 15:8 (from A) and 7:0 (from A+1) after extension.
- **Address indexing:** the array is indexed by `req_addr` modulo `DEPTH_BYTES`. Upper bits are ignored, with no fault.
- **Stores:** write the low 1, 2 or 4 bytes of `req_wdata` into the array on the acceptance edge. A load accepted on the next cycle sees the new data.
- **Loads:** read the array on the acceptance edge. Later stores never alter a load already in flight.
- **Pipeline:** `READ_LAT` stages. Each stage holds valid, fault, we, size, unsigned, byte offset and raw 32-bit data.
  - The pipeline advances when the output stage is empty or `rsp_ready` = 1.
  - `req_ready` = advance && !`rst`.
- **Extension:** applied in the final stage. A byte or halfword is sign-extended from its top bit unless `req_unsigned` is set.
- **Reserved size (3):** always faults, with no write.
- **Reset:** clears all stage valid bits, so in-flight requests are dropped and no response is issued for them. Memory contents are not reset.
- **Reset outputs:** `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_fault` = 0, `req_ready` = 0 while `rst` is high.
- **Write in the same cycle as a stalled response:** permitted only when accepted, and acceptance requires the pipeline to advance.

## Timing
- **Latency:** a request accepted at edge T produces `rsp_valid` = 1 in the cycle after edge T+`READ_LAT`−1. With `READ_LAT` = 1, the response is visible in the cycle immediately after acceptance.
- **Throughput:** one request per cycle when `rsp_ready` is held at 1.
- **Stall:** `rsp_valid` && !`rsp_ready` holds every stage, and `rsp_rdata`/`rsp_fault` stay stable. `req_ready` drops combinationally in the same cycle.
- **No bubbles:** a valid response with `rsp_ready` = 1 and a new acceptance on the same edge both proceed.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A halfword with an odd address, or a word with `addr[1:0]` != 0, is misaligned.
  - A misaligned access returns `rsp_fault` = 1 and `rsp_rdata` = 0.
  - A misaligned store does not write.
- `DMEM_ALIGN_CHECK_EN` undefined:
  - Misaligned accesses are not flagged.
  - Bytes are accessed at consecutive addresses with modulo-`DEPTH_BYTES` wrap. For example, a word at `DEPTH_BYTES`−2 touches bytes −2, −1, 0, 1.
  - Reserved size still faults.

## Structure
- Package `dmem_pkg` holds:
  - the size constants: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_RSVD`;
  - the pipeline stage struct type;
  - the function `dmem_misaligned(size, addr_lo)`.
- Sub-module `dmem_extend`, purely combinational: selects lanes from the raw word and applies sign or zero extension. It is instantiated once, in the final stage.
- The array, write logic and stage registers live in the top module.

## Test plan
- **Reset mid-stream:** with `READ_LAT` = 3, issue 3 loads and assert `rst` for 1 cycle. Required: no `rsp_valid` follows, and memory written earlier is unchanged.
- **Word round trip:** store word 0x11223344 at 0x10, then load byte at 0x10 signed. Required: 0x00000011 after `READ_LAT` cycles. Load halfword at 0x12 unsigned. Required: 0x00003344.
- **Sign extension:** store byte 0x80 at 0x20, then load it signed. Required: 0xFFFFFF80. Load it unsigned. Required: 0x00000080.
- **Backpressure:** hold `rsp_ready` = 0 with 4 loads offered. Required: `req_ready` drops once all stages are full, the response is stable, and release yields all 4 responses in order with no loss.
- **Misaligned store (`DMEM_ALIGN_CHECK_EN` defined):** word store at 0x21. Required: `rsp_fault` = 1, and a subsequent word load at 0x20 returns the prior contents.
- **Wrap (`DMEM_ALIGN_CHECK_EN` undefined):** word store 0xAABBCCDD at 254 with `DEPTH_BYTES` = 256. Required: bytes 254, 255, 0, 1 hold AA, BB, CC, DD.
